// File: rtl/cmos_cap_pkg.sv
// Shared format codes and pixel-expansion helpers for the multi-format camera capture.
package cmos_cap_pkg;

    localparam logic [1:0] FMT_RGB565 = 2'd0;
    localparam logic [1:0] FMT_RGB888 = 2'd1;
    localparam logic [1:0] FMT_GRAY8  = 2'd2;

    // Bytes per pixel; the reserved code behaves as GRAY8.
    function automatic logic [1:0] bpp(input logic [1:0] fmt);
        case (fmt)
            FMT_RGB565: return 2'd2;
            FMT_RGB888: return 2'd3;
            FMT_GRAY8:  return 2'd1;
            default:    return 2'd1;
        endcase
    endfunction

    // Upper bits are replicated into the low bits of each channel.
    function automatic logic [23:0] rgb565_to_888(input logic [7:0] b0, input logic [7:0] b1);
        return {b0[7:3], b0[7:5], b0[2:0], b1[7:5], b0[2:1], b1[4:0], b1[4:2]};
    endfunction

endpackage

// File: rtl/cmos_pix_pack.sv
// Byte-phase counter and pixel assembler: turns the registered byte stream into 24-bit
// pixels one cycle after the last byte of each pixel, and flags lines ending mid-pixel.
module cmos_pix_pack
    import cmos_cap_pkg::*;
(
    input  logic        cam_pclk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic [1:0]  fmt,
    input  logic        line_end,
    input  logic        flush,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic        err_partial
);

    logic [1:0]  ph_q, ph_d;
    logic [1:0]  last_ph;
    logic [7:0]  b0_q, b0_d, b1_q, b1_d;
    logic        done;
    logic [23:0] pix_d;

    always_comb begin
        ph_d    = ph_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        last_ph = bpp(fmt) - 2'd1;
        done    = byte_valid && !flush && (ph_q >= last_ph);

        if (!byte_valid || flush || done) begin
            ph_d = 2'd0;
        end else begin
            ph_d = ph_q + 2'd1;
            if (ph_q == 2'd0) begin
                b0_d = byte_data;
            end else begin
                b1_d = byte_data;
            end
        end

        case (fmt)
            FMT_RGB565: pix_d = rgb565_to_888(b0_q, byte_data);
            FMT_RGB888: pix_d = {b0_q, b1_q, byte_data};
            default:    pix_d = {byte_data, byte_data, byte_data};
        endcase
    end

    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            ph_q        <= 2'd0;
            b0_q        <= 8'd0;
            b1_q        <= 8'd0;
            pix_valid   <= 1'b0;
            pix_data    <= 24'd0;
            err_partial <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            pix_valid   <= done;
            // ph still holds the stale phase on the first cycle after href drops.
            err_partial <= line_end && (ph_q != 2'd0);
            if (done) begin
                pix_data <= pix_d;
            end
        end
    end

endmodule

// File: rtl/cmos_capture_multi.sv
// Multi-format camera capture: input sync, settle gating, frame/line/column counters and
// markers around the pixel assembler.
module cmos_capture_multi
    import cmos_cap_pkg::*;
#(
    parameter int unsigned WAIT_FRAME = 10,
    parameter int unsigned X_W        = 11,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned FCNT_W     = 16
) (
    input  logic              cam_pclk,
    input  logic              rst,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic [1:0]        fmt_sel,
    output logic              cam_rst_n,
    output logic              cam_sgm_ctrl,
    output logic              pix_valid,
    output logic [23:0]       pix_data,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic [X_W-1:0]    pix_x,
    output logic [Y_W-1:0]    pix_y,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              frame_vsync,
    output logic              err_partial,
    output logic              capture_en
);

    localparam logic [7:0] WaitCnt = 8'(WAIT_FRAME);

    logic              vs_d0, vs_d1, hr_d0, hr_d1;
    logic [7:0]        dat_d0;
    logic              pos_vs, hr_fall, flush;
    logic [7:0]        settle_q;
    logic              wait_done_q;
    logic [1:0]        fmt_q;
    logic              pk_valid, pk_err;
    logic [23:0]       pk_data;
    logic [X_W-1:0]    col_q;
    logic [Y_W-1:0]    row_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic              sof_pend_q, has_pix_q, eol_q;
    logic              line_has_pix;

    assign pos_vs       = vs_d0 & ~vs_d1;
    assign hr_fall      = hr_d1 & ~hr_d0;
    // A vsync edge during an active line is a sensor fault: drop the line state.
    assign flush        = pos_vs & hr_d0;
    // The last pixel of a line lands in the same cycle as the href fall.
    assign line_has_pix = has_pix_q | pk_valid;

    cmos_pix_pack u_pix_pack (
        .cam_pclk    (cam_pclk),
        .rst         (rst),
        .byte_valid  (hr_d0),
        .byte_data   (dat_d0),
        .fmt         (fmt_q),
        .line_end    (hr_fall),
        .flush       (flush),
        .pix_valid   (pk_valid),
        .pix_data    (pk_data),
        .err_partial (pk_err)
    );

    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            vs_d0       <= 1'b0;
            vs_d1       <= 1'b0;
            hr_d0       <= 1'b0;
            hr_d1       <= 1'b0;
            dat_d0      <= 8'd0;
            settle_q    <= 8'd0;
            wait_done_q <= 1'b0;
            fmt_q       <= FMT_RGB565;
            fcnt_q      <= '0;
        end else begin
            vs_d0  <= cam_vsync;
            vs_d1  <= vs_d0;
            hr_d0  <= cam_href;
            hr_d1  <= hr_d0;
            dat_d0 <= cam_data;
            if (pos_vs) begin
                fmt_q <= fmt_sel;
                if (settle_q == WaitCnt) begin
                    wait_done_q <= 1'b1;
                end else begin
                    settle_q <= settle_q + 8'd1;
                end
                if (wait_done_q) begin
                    fcnt_q <= fcnt_q + FCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            sof_pend_q <= 1'b0;
            has_pix_q  <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            eol_q <= hr_fall & line_has_pix;
            if (pos_vs) begin
                sof_pend_q <= 1'b1;
                col_q      <= '0;
                row_q      <= '0;
                has_pix_q  <= 1'b0;
            end else begin
                if (pk_valid) begin
                    sof_pend_q <= 1'b0;
                end
                if (hr_fall) begin
                    col_q     <= '0;
                    has_pix_q <= 1'b0;
                    if (line_has_pix && row_q != '1) begin
                        row_q <= row_q + Y_W'(1);
                    end
                end else if (pk_valid) begin
                    has_pix_q <= 1'b1;
                    if (col_q != '1) begin
                        col_q <= col_q + X_W'(1);
                    end
                end
            end
        end
    end

    assign cam_rst_n    = 1'b1;
    assign cam_sgm_ctrl = 1'b1;
    assign capture_en   = wait_done_q;
    assign frame_vsync  = vs_d0 & wait_done_q;
    assign frame_cnt    = fcnt_q;
    assign pix_valid    = pk_valid & wait_done_q;
    assign pix_data     = pk_data;
    assign pix_sof      = pk_valid & sof_pend_q & wait_done_q;
    assign pix_eol      = eol_q & wait_done_q;
    assign err_partial  = pk_err & wait_done_q;
    assign pix_x        = col_q;
    assign pix_y        = row_q;

endmodule

// File: doc/cmos_capture_multi.md
Name: cmos_capture_multi

Overview:
- Parametrised successor to the single-format OV7725 capture stage.
- Samples the camera's byte stream on cam_pclk and assembles pixels in a run-time selectable format: RGB565, RGB888 or GRAY8.
- Emits a 24-bit RGB pixel stream with frame and line markers, pixel and line coordinates, a frame counter and error flags.
- Sits between the camera pins and the video FIFO / AXI-Stream bridge.

Parameters:
- WAIT_FRAME, 10: number of vsync rising edges ignored after reset while sensor registers settle (0..255).
- X_W, 11: width of the pixel-column counter.
- Y_W, 10: width of the line counter.
- FCNT_W, 16: width of the frame counter.

Ports:
- cam_pclk  in  1  camera pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cam_vsync  in  1  camera frame sync, active high.
- cam_href  in  1  camera line-valid.
- cam_data  in  8  camera byte.
- fmt_sel  in  2  format select: 0 = RGB565, 1 = RGB888, 2 = GRAY8, 3 = reserved (treated as GRAY8).
- cam_rst_n  out  1  sensor reset, constant 1.
- cam_sgm_ctrl  out  1  sensor clock select, constant 1.
- pix_valid  out  1  one-cycle strobe: pix_data is valid.
- pix_data  out  24  {R8, G8, B8}.
- pix_sof  out  1  qualifies the first pixel of a frame.
- pix_eol  out  1  one-cycle pulse after the last byte of a line.
- pix_x  out  X_W  column of the current pixel.
- pix_y  out  Y_W  line of the current pixel.
- frame_cnt  out  FCNT_W  completed frames; wraps.
- frame_vsync  out  1  registered vsync, gated by wait_done.
- err_partial  out  1  one-cycle pulse: line ended mid-pixel.
- capture_en  out  1  wait_done status.

Behaviour:
- Reset: all registered outputs are 0, except cam_rst_n = 1 and cam_sgm_ctrl = 1. Reset mid-frame discards any partial pixel and restarts the WAIT_FRAME count.
- Input stage: cam_vsync, cam_href and cam_data are registered once into vs_d0, hr_d0 and dat_d0. vs_d1 is a second stage of vs_d0. pos_vs = vs_d0 & ~vs_d1.
- Settle counter: saturates at WAIT_FRAME and increments on pos_vs. wait_done is set on the pos_vs where the count already equals WAIT_FRAME. With WAIT_FRAME = 0, wait_done is set on the first pos_vs. wait_done clears only on rst.
- Format latch: fmt_sel is latched into fmt_q on every pos_vs. Changes of fmt_sel mid-frame have no effect until the next frame.
- Byte phase counter ph: counts 0..BPP-1 while hr_d0 = 1, where BPP is 2 for RGB565, 3 for RGB888 and 1 for GRAY8. ph returns to 0 while hr_d0 = 0.
- Pixel assembly and output latency: on the cycle where hr_d0 = 1 and ph = BPP-1, the pixel is complete. pix_valid and pix_data are registered on the next edge, i.e. 1 cycle after the last byte reaches dat_d0.
- RGB565 (bytes b0 then b1): R = {b0[7:3], b0[7:5]}, G = {b0[2:0], b1[7:5], b0[2:1]}, B = {b1[4:0], b1[4:2]}. Upper bits are replicated into the low bits; no zero fill.
- RGB888: pix_data = {b0, b1, b2}.
- GRAY8: pix_data = {b0, b0, b0}.
- Gating: pix_valid, pix_sof, pix_eol and err_partial are forced to 0 while wait_done = 0.
- Column counter pix_x: 0 on the first pixel of a line, +1 per pixel, saturating at all-ones.
- Line counter pix_y: cleared on pos_vs; +1 on each href falling edge that produced at least one pixel; saturating.
- pix_sof: asserted together with pix_valid for the first pixel after pos_vs.
- pix_eol: pulses 1 cycle after hr_d0 falls, only if the line produced at least one pixel.
- err_partial: pulses at the same cycle as pix_eol whenever hr_d0 falls with ph != 0. The partial bytes are dropped. It also fires on lines that produced no pixel.
- frame_cnt: +1 on each pos_vs once wait_done = 1; wraps at 2^FCNT_W.
- Simultaneous events: pos_vs coincident with hr_d0 = 1 is a sensor fault. The line state is cleared, ph = 0, and no eol is emitted.

Decomposition:
- Package cmos_cap_pkg holds:
  - FMT_RGB565 = 2'd0, FMT_RGB888 = 2'd1, FMT_GRAY8 = 2'd2;
  - function bpp(fmt), returning 2, 3 or 1;
  - function rgb565_to_888.
- Sub-module cmos_pix_pack:
  - ports: cam_pclk, rst, byte valid, byte, fmt, line-end;
  - contains the ph counter, byte shift register, format expansion and the partial-error detect;
  - outputs pixel valid and data with 1-cycle latency.
- The top level keeps sync, settle counter, counters and gating.

Test Plan:
- Settle gating: WAIT_FRAME = 2, rst, 4 frames of 4 px × 2 lines of RGB565. Required: no pix_valid in frames 1–2; wait_done set on the 3rd pos_vs; frame 3 yields 8 pix_valid with pix_sof on the first; frame_cnt = 1 after the 4th pos_vs.
- RGB565 expansion: bytes 0xF8, 0x1F → pix_data 0xFF00FF. Bytes 0x07, 0xE0 → 0x00FF00. Latency is 1 cycle after the second byte is registered.
- RGB888 and GRAY8: bytes 0x12, 0x34, 0x56 with fmt 1 → 0x123456. Byte 0xA5 with fmt 2 → 0xA5A5A5. 640 px line → pix_x 0..639, one pix_eol.
- Mid-frame fmt change: fmt_sel 0 → 1 during a line. That frame still decodes as RGB565; the next frame decodes as RGB888.
- Partial pixel: RGB888 line of 7 bytes → 2 pix_valid, and err_partial pulses together with pix_eol.
- Reset mid-line: assert rst after byte 1 of an RGB565 pixel. Outputs go to 0 next cycle, no pix_valid is emitted, and the settle count restarts.
